// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// Optional build macro: HAZARD_PERF_EN (adds per-cause stall counters).
package hazard_pkg;

   // Data-memory handshake FSM
   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MEMWAIT = 1'b1
   } memState_t;

   // Execute forward-mux select encodings
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Width of the optional stall-cause counters
   localparam int unsigned PERF_W = 32;

   // Memory stage wins over writeback when both hold the operand
   function automatic logic [1:0] fwdSel(input logic hitM, input logic hitW);
      if (hitM)      return FWD_MEM;
      else if (hitW) return FWD_WB;
      else           return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_cnt.sv
// Small CW-bit counter: clear, load, saturating increment, decrement-to-zero.
module hazard_cnt #(
   parameter int unsigned CW = 7
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          load,
   input  logic          inc,
   input  logic          dec,
   input  logic [CW-1:0] loadVal,
   output logic [CW-1:0] count,
   output logic          zero
);

   // Clear beats load beats inc beats dec; never wraps in either direction
   always_ff @(posedge clk) begin
      if (!reset || clear)            count <= '0;
      else if (load)                  count <= loadVal;
      else if (inc && (count != '1))  count <= count + 1'b1;
      else if (dec && (count != '0))  count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load-use/branch/mul-div stalls,
// memory-handshake stalls with timeout flag.
// Optional build macro: HAZARD_PERF_EN (perf_lw/perf_br/perf_md/perf_mem outputs).
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned RW     = 5,
   parameter int unsigned MD_LAT = 32,
   parameter int unsigned MEM_TO = 64,
   parameter int unsigned CW     = 7
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          branchD,
   input  logic          jumpD,
   input  logic          mdopD,
   input  logic [RW-1:0] rsD,
   input  logic [RW-1:0] rtD,
   input  logic [RW-1:0] rsE,
   input  logic [RW-1:0] rtE,
   input  logic [RW-1:0] writeregE,
   input  logic [RW-1:0] writeregM,
   input  logic [RW-1:0] writeregW,
   input  logic          regwriteE,
   input  logic          regwriteM,
   input  logic          regwriteW,
   input  logic          memtoregE,
   input  logic          memtoregM,
   input  logic          mdstartE,
   input  logic          memreqM,
   input  logic          memreadyM,
   output logic          StallF,
   output logic          StallD,
   output logic          StallE,
   output logic          StallM,
   output logic          FlushD,
   output logic          FlushE,
   output logic          FlushW,
   output logic          ForwardAD,
   output logic          ForwardBD,
   output logic [1:0]    ForwardAE,
   output logic [1:0]    ForwardBE,
   output logic          mdbusy,
   output logic          mddone,
   output logic          memerr
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_lw,
   output logic [PERF_W-1:0] perf_br,
   output logic [PERF_W-1:0] perf_md,
   output logic [PERF_W-1:0] perf_mem
`endif
);

   memState_t     state;
   logic          memwait, lwstall, brstall, mdstall;
   logic          mdActive, mdZero, mdLoad, waitZero;
   logic [CW-1:0] mdCount, waitCnt;
   logic          unusedCnt;

   // Register 0 is hardwired, so a write to it never creates a dependency
   logic validE, validM, validW;
   assign validE = regwriteE && (writeregE != '0);
   assign validM = regwriteM && (writeregM != '0);
   assign validW = regwriteW && (writeregW != '0);

   assign ForwardAE = fwdSel(validM && (writeregM == rsE), validW && (writeregW == rsE));
   assign ForwardBE = fwdSel(validM && (writeregM == rtE), validW && (writeregW == rtE));
   assign ForwardAD = validM && (writeregM == rsD);
   assign ForwardBD = validM && (writeregM == rtD);

   assign lwstall = memtoregE && (writeregE != '0) &&
                    ((writeregE == rsD) || (writeregE == rtD));
   assign brstall = branchD &&
                    ((validE && ((writeregE == rsD) || (writeregE == rtD))) ||
                     (memtoregM && (writeregM != '0) &&
                      ((writeregM == rsD) || (writeregM == rtD))));
   assign mdstall = mdopD && mdbusy;
   assign memwait = memreqM && !memreadyM;

   // Stall/flush priority: memory wait freezes everything, else hazard bubble
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (memwait) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (lwstall || brstall || mdstall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
      // jumpD already carries the datapath's branch-taken term
      FlushD = jumpD && !StallD;
   end

   // Memory handshake FSM
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else begin
         case (state)
            IDLE:    if (memwait)   state <= MEMWAIT;
            MEMWAIT: if (memreadyM) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Counts consecutive waiting cycles (including the IDLE cycle that enters
   // MEMWAIT), so the flag rises after exactly MEM_TO waiting cycles
   hazard_cnt #(.CW(CW)) uWaitCnt (
      .clk(clk), .reset(reset), .clear(!memwait), .load(1'b0),
      .inc(memwait), .dec(1'b0), .loadVal('0),
      .count(waitCnt), .zero(waitZero)
   );

   // Sticky timeout flag
   always_ff @(posedge clk) begin
      if (!reset) memerr <= 1'b0;
      else if (memwait && (waitCnt == CW'(MEM_TO - 1))) memerr <= 1'b1;
   end

   // Mul/div tracker: count runs MD_LAT-1..0; busy while nonzero, done at zero
   assign mdbusy = mdActive && !mdZero;
   assign mddone = mdActive && mdZero;
   assign mdLoad = mdstartE && !mdbusy && !StallE;

   hazard_cnt #(.CW(CW)) uMdCnt (
      .clk(clk), .reset(reset), .clear(1'b0), .load(mdLoad),
      .inc(1'b0), .dec(mdActive), .loadVal(CW'(MD_LAT - 1)),
      .count(mdCount), .zero(mdZero)
   );

   // Operation-in-flight flag; survives the done cycle only on back-to-back issue
   always_ff @(posedge clk) begin
      if (!reset)      mdActive <= 1'b0;
      else if (mdLoad) mdActive <= 1'b1;
      else if (mdZero) mdActive <= 1'b0;
   end

   assign unusedCnt = &{1'b0, waitZero, mdCount};

`ifdef HAZARD_PERF_EN
   // Saturating stall-cycle counters, one cause per cycle by stall priority
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_lw  <= '0;
         perf_br  <= '0;
         perf_md  <= '0;
         perf_mem <= '0;
      end else if (memwait) begin
         if (perf_mem != '1) perf_mem <= perf_mem + 1'b1;
      end else if (lwstall) begin
         if (perf_lw != '1) perf_lw <= perf_lw + 1'b1;
      end else if (brstall) begin
         if (perf_br != '1) perf_br <= perf_br + 1'b1;
      end else if (mdstall) begin
         if (perf_md != '1) perf_md <= perf_md + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// expected outputs from a cycle-level reference model.
module tb_hazard_ctrl;

   localparam int RW     = 5;
   localparam int MD_LAT = 4;
   localparam int MEM_TO = 4;
   localparam int CW     = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, branchD, jumpD, mdopD;
   logic [RW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic          regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
   logic          mdstartE, memreqM, memreadyM;
   logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic          ForwardAD, ForwardBD, mdbusy, mddone, memerr;
   logic [1:0]    ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
   logic [31:0]   perf_lw, perf_br, perf_md, perf_mem;
`endif

   hazard_ctrl #(.RW(RW), .MD_LAT(MD_LAT), .MEM_TO(MEM_TO), .CW(CW)) dut (
      .clk(clk), .reset(reset), .branchD(branchD), .jumpD(jumpD), .mdopD(mdopD),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
      .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
      .memtoregE(memtoregE), .memtoregM(memtoregM), .mdstartE(mdstartE),
      .memreqM(memreqM), .memreadyM(memreadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .mdbusy(mdbusy), .mddone(mddone), .memerr(memerr)
`ifdef HAZARD_PERF_EN
      , .perf_lw(perf_lw), .perf_br(perf_br), .perf_md(perf_md), .perf_mem(perf_mem)
`endif
   );

   typedef struct packed {
      logic rst, branchD, jumpD, mdopD;
      logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
      logic rwE, rwM, rwW, mtrE, mtrM, mdstartE, memreqM, memreadyM;
   } stim_t;

   typedef struct packed {
      logic [3:0]  stall;   // F D E M
      logic [2:0]  flush;   // D E W
      logic [1:0]  fwdD;    // AD BD
      logic [1:0]  fae, fbe;
      logic [1:0]  md;      // busy done
      logic        merr;
      logic [31:0] pLw, pBr, pMd, pMem;
   } exp_t;

   exp_t expQ[$];
   int   nAssert = 0;
   int   nFail   = 0;

   // Reference model state, in terms of cycle numbers and run lengths
   int cyc = 0;
   bit mdActive = 0;
   int mdDoneCyc = 0;
   int waitRun = 0;
   bit mErr = 0;
   int pLw = 0, pBr = 0, pMd = 0, pMem = 0;

   function automatic stim_t idle();
      stim_t s = '0;
      s.rst = 1'b1;
      return s;
   endfunction

   function automatic logic [1:0] fwdE(input logic [4:0] src, input stim_t s);
      if (s.rwM && s.wM != 0 && s.wM == src) return 2'b10;
      if (s.rwW && s.wW != 0 && s.wW == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit srcHit(input logic [4:0] w, input stim_t s);
      return (w != 0) && (w == s.rsD || w == s.rtD);
   endfunction

   task automatic step(input stim_t s, input bit chk);
      exp_t e;
      bit busy, done, mw, lw, br, mds;
      @(posedge clk);
      #1;
      reset = s.rst; branchD = s.branchD; jumpD = s.jumpD; mdopD = s.mdopD;
      rsD = s.rsD; rtD = s.rtD; rsE = s.rsE; rtE = s.rtE;
      writeregE = s.wE; writeregM = s.wM; writeregW = s.wW;
      regwriteE = s.rwE; regwriteM = s.rwM; regwriteW = s.rwW;
      memtoregE = s.mtrE; memtoregM = s.mtrM; mdstartE = s.mdstartE;
      memreqM = s.memreqM; memreadyM = s.memreadyM;

      busy = mdActive && (cyc < mdDoneCyc);
      done = mdActive && (cyc == mdDoneCyc);
      mw   = s.memreqM && !s.memreadyM;
      lw   = s.mtrE && srcHit(s.wE, s);
      br   = s.branchD && ((s.rwE && srcHit(s.wE, s)) || (s.mtrM && srcHit(s.wM, s)));
      mds  = s.mdopD && busy;

      e = '0;
      if (mw) begin
         e.stall = 4'b1111;
         e.flush[0] = 1'b1;
      end else if (lw || br || mds) begin
         e.stall = 4'b1100;
         e.flush[1] = 1'b1;
      end
      e.flush[2] = s.jumpD && !e.stall[2];
      e.fwdD = {s.rwM && s.wM != 0 && s.wM == s.rsD, s.rwM && s.wM != 0 && s.wM == s.rtD};
      e.fae  = fwdE(s.rsE, s);
      e.fbe  = fwdE(s.rtE, s);
      e.md   = {busy, done};
      e.merr = mErr;
      e.pLw = pLw; e.pBr = pBr; e.pMd = pMd; e.pMem = pMem;
      if (chk) expQ.push_back(e);

      if (!s.rst) begin
         mdActive = 0; waitRun = 0; mErr = 0;
         pLw = 0; pBr = 0; pMd = 0; pMem = 0;
      end else begin
         if (s.mdstartE && !busy && !mw) begin
            mdActive  = 1;
            mdDoneCyc = cyc + MD_LAT;
         end else if (done) mdActive = 0;
         if (mw) begin
            waitRun++;
            if (waitRun >= MEM_TO) mErr = 1;
         end else waitRun = 0;
         if (mw) pMem++;
         else if (lw) pLw++;
         else if (br) pBr++;
         else if (mds) pMd++;
      end
      cyc++;
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nAssert++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s @%0t got %h expected %h", nm, $time, got, exp);
      end
   endtask

   // Monitor: compares DUT outputs mid-cycle against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("stalls",  {28'd0, StallF, StallD, StallE, StallM}, {28'd0, e.stall});
            check("flushes", {29'd0, FlushD, FlushE, FlushW}, {29'd0, e.flush});
            check("fwdD",    {30'd0, ForwardAD, ForwardBD}, {30'd0, e.fwdD});
            check("fwdAE",   {30'd0, ForwardAE}, {30'd0, e.fae});
            check("fwdBE",   {30'd0, ForwardBE}, {30'd0, e.fbe});
            check("muldiv",  {30'd0, mdbusy, mddone}, {30'd0, e.md});
            check("memerr",  {31'd0, memerr}, {31'd0, e.merr});
`ifdef HAZARD_PERF_EN
            check("perf_lw",  perf_lw,  e.pLw);
            check("perf_br",  perf_br,  e.pBr);
            check("perf_md",  perf_md,  e.pMd);
            check("perf_mem", perf_mem, e.pMem);
`endif
         end
      end
   end

   initial begin
      stim_t s;
      s = idle();
      s.rst = 1'b0;
      step(s, 1'b0);                                   // DUT state unknown before this edge
      step(s, 1'b1);                                   // reset values
      // Forwarding priority and register 0
      s = idle(); s.wM = 5; s.rwM = 1; s.rsE = 5; s.wW = 5; s.rwW = 1; s.rtE = 5;
      step(s, 1'b1);
      s.rwM = 0;  step(s, 1'b1);
      s.rsE = 0;  step(s, 1'b1);
      // Load-use on $8 then forward from M
      s = idle(); s.mtrE = 1; s.rwE = 1; s.wE = 8; s.rsD = 8; s.jumpD = 1;
      step(s, 1'b1);
      s = idle(); s.wM = 8; s.rwM = 1; s.rsE = 8; step(s, 1'b1);
      // Three memory wait cycles overlapping a load-use, then release
      s = idle(); s.memreqM = 1; s.mtrE = 1; s.wE = 3; s.rtD = 3;
      repeat (3) step(s, 1'b1);
      s.memreadyM = 1; step(s, 1'b1);
      step(idle(), 1'b1);
      // Mul/div with a dependent mdop from cycle 2
      s = idle(); s.mdstartE = 1; step(s, 1'b1);
      step(idle(), 1'b1);
      s = idle(); s.mdopD = 1; repeat (4) step(s, 1'b1);
      step(idle(), 1'b1);
      // Timeout: stays waiting, flag sticky past ready, cleared by reset
      s = idle(); s.memreqM = 1; repeat (6) step(s, 1'b1);
      s.memreadyM = 1; step(s, 1'b1);
      repeat (2) step(idle(), 1'b1);
      s = idle(); s.rst = 0; step(s, 1'b1);
      step(idle(), 1'b1);
      // Reset in the middle of a mul/div
      s = idle(); s.mdstartE = 1; step(s, 1'b1);
      step(idle(), 1'b1);
      s = idle(); s.rst = 0; step(s, 1'b1);
      repeat (3) step(idle(), 1'b1);
      // Random traffic on a small register set to force collisions
      for (int i = 0; i < 3000; i++) begin
         s.rst       = ($urandom_range(99) >= 1);
         s.branchD   = ($urandom_range(99) < 20);
         s.jumpD     = ($urandom_range(99) < 10);
         s.mdopD     = ($urandom_range(99) < 30);
         s.rsD = 5'($urandom_range(3)); s.rtD = 5'($urandom_range(3));
         s.rsE = 5'($urandom_range(3)); s.rtE = 5'($urandom_range(3));
         s.wE  = 5'($urandom_range(3)); s.wM  = 5'($urandom_range(3));
         s.wW  = 5'($urandom_range(3));
         s.rwE = $urandom_range(1); s.rwM = $urandom_range(1); s.rwW = $urandom_range(1);
         s.mtrE = ($urandom_range(99) < 25); s.mtrM = ($urandom_range(99) < 25);
         s.mdstartE  = ($urandom_range(99) < 15);
         s.memreqM   = ($urandom_range(99) < 35);
         s.memreadyM = ($urandom_range(99) < 55);
         step(s, 1'b1);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      check("queue_drained", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
